// File: rtl/writeback_scoreboard.sv
// Write-back stage: registers the MEM-stage result onto the register-file write port and
// tracks outstanding writes per register so decode can be stalled on RAW hazards.
module writeback_scoreboard #(
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned CNT_W    = 2,
    parameter int unsigned DATA_W   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              issue_valid,
    input  logic              issue_reg_write,
    input  logic [4:0]        issue_dest,
    input  logic [4:0]        issue_rs,
    input  logic [4:0]        issue_rt,
    input  logic              issue_use_rt,
    output logic              stall,
    input  logic              mem_valid,
    input  logic              mem_reg_write,
    input  logic              mem_to_reg,
    input  logic [4:0]        mem_dest,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] mem_read_data,
    output logic              write_en,
    output logic [4:0]        write_reg,
    output logic [DATA_W-1:0] write_data,
    output logic              busy
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0]    cnt_q [NUM_REGS];
    logic [CNT_W-1:0]    cnt_d [NUM_REGS];
    logic                write_en_q;
    logic [4:0]          write_reg_q;
    logic [DATA_W-1:0]   write_data_q;
    logic [NUM_REGS-1:0] retire;
    logic [NUM_REGS-1:0] pending;
    logic [NUM_REGS-1:0] inc;
    logic [NUM_REGS-1:0] dec;
    logic                dest_full;
    logic                accept;

    // The register file writes in the first half-cycle, so a retiring write is already visible.
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            retire[r]  = write_en_q && (write_reg_q == 5'(r));
            pending[r] = (r != 0) &&
                         (cnt_q[r] > (retire[r] ? CNT_W'(1) : CNT_W'(0)));
        end
    end

    always_comb begin
        dest_full = issue_reg_write && (issue_dest != '0) &&
                    (cnt_q[issue_dest] == CNT_MAX) && !retire[issue_dest];
        stall     = issue_valid &&
                    (pending[issue_rs] || (issue_use_rt && pending[issue_rt]) || dest_full);
        accept    = issue_valid && !stall;
    end

    always_comb begin
        busy = 1'b0;
        for (int r = 0; r < NUM_REGS; r++) begin
            inc[r]   = accept && issue_reg_write && (r != 0) && (issue_dest == 5'(r));
            dec[r]   = retire[r] && (cnt_q[r] != '0);
            cnt_d[r] = cnt_q[r];
            if (inc[r] && !dec[r] && (cnt_q[r] != CNT_MAX)) begin
                cnt_d[r] = cnt_q[r] + CNT_W'(1);
            end else if (dec[r] && !inc[r]) begin
                cnt_d[r] = cnt_q[r] - CNT_W'(1);
            end
            busy = busy | (cnt_q[r] != '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt_q[r] <= '0;
            end
            write_en_q   <= 1'b0;
            write_reg_q  <= '0;
            write_data_q <= '0;
        end else begin
            cnt_q        <= cnt_d;
            write_en_q   <= mem_valid && mem_reg_write && (mem_dest != '0);
            write_reg_q  <= mem_dest;
            write_data_q <= mem_to_reg ? mem_read_data : alu_result;
        end
    end

    assign write_en   = write_en_q;
    assign write_reg  = write_reg_q;
    assign write_data = write_data_q;

    // A retire with nothing outstanding means the pipeline lost track of an issue.
    retire_has_pending: assert property (@(posedge clk) disable iff (!rst_n)
        write_en_q |-> (cnt_q[write_reg_q] != '0));

endmodule

// File: tb/tb_writeback_scoreboard.sv
// Directed and random stimulus for writeback_scoreboard, checked against an
// outstanding-write count model kept per register.
module tb_writeback_scoreboard;

    localparam int MAX_INFLIGHT = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        issue_valid, issue_reg_write, issue_use_rt;
    logic [4:0]  issue_dest, issue_rs, issue_rt;
    logic        stall;
    logic        mem_valid, mem_reg_write, mem_to_reg;
    logic [4:0]  mem_dest;
    logic [31:0] alu_result, mem_read_data;
    logic        write_en;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic        busy;

    int checks = 0;
    int errors = 0;

    // Model: writes accepted at decode but not yet seen on the write port, per register.
    int          outstanding [32];
    logic [4:0]  inflight [$];
    logic        m_we = 1'b0;
    logic [4:0]  m_wr = '0;
    logic [31:0] m_wd = '0;

    writeback_scoreboard #(
        .NUM_REGS(32),
        .CNT_W   (2),
        .DATA_W  (32)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .issue_valid    (issue_valid),
        .issue_reg_write(issue_reg_write),
        .issue_dest     (issue_dest),
        .issue_rs       (issue_rs),
        .issue_rt       (issue_rt),
        .issue_use_rt   (issue_use_rt),
        .stall          (stall),
        .mem_valid      (mem_valid),
        .mem_reg_write  (mem_reg_write),
        .mem_to_reg     (mem_to_reg),
        .mem_dest       (mem_dest),
        .alu_result     (alu_result),
        .mem_read_data  (mem_read_data),
        .write_en       (write_en),
        .write_reg      (write_reg),
        .write_data     (write_data),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL timeout: observed no finish, expected finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit pend(input logic [4:0] r);
        int left;
        left = outstanding[r] - ((m_we && m_wr == r) ? 1 : 0);
        return (r != 0) && (left > 0);
    endfunction

    function automatic bit model_stall();
        bit full;
        if (!issue_valid) return 1'b0;
        full = issue_reg_write && issue_dest != 0 &&
               outstanding[issue_dest] >= MAX_INFLIGHT && !(m_we && m_wr == issue_dest);
        return pend(issue_rs) || (issue_use_rt && pend(issue_rt)) || full;
    endfunction

    function automatic bit model_busy();
        for (int r = 0; r < 32; r++) if (outstanding[r] != 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < 32; r++) outstanding[r] = 0;
        inflight.delete();
        m_we = 1'b0;
        m_wr = '0;
        m_wd = '0;
    endtask

    task automatic set_issue(input bit v, input bit rw, input logic [4:0] d,
                             input logic [4:0] s, input logic [4:0] t, input bit ut);
        issue_valid     = v;
        issue_reg_write = rw;
        issue_dest      = d;
        issue_rs        = s;
        issue_rt        = t;
        issue_use_rt    = ut;
    endtask

    task automatic set_mem(input bit v, input bit rw, input bit tr, input logic [4:0] d,
                           input logic [31:0] alu, input logic [31:0] rd);
        mem_valid     = v;
        mem_reg_write = rw;
        mem_to_reg    = tr;
        mem_dest      = d;
        alu_result    = alu;
        mem_read_data = rd;
    endtask

    task automatic idle();
        set_issue(0, 0, 5'd0, 5'd0, 5'd0, 0);
        set_mem(0, 0, 0, 5'd0, 32'h0, 32'h0);
    endtask

    task automatic settle();
        @(negedge clk);
        check("stall", {31'b0, stall}, {31'b0, model_stall()});
        check("busy", {31'b0, busy}, {31'b0, model_busy()});
        check("write_en", {31'b0, write_en}, {31'b0, m_we});
        check("write_reg", {27'b0, write_reg}, {27'b0, m_wr});
        check("write_data", write_data, m_wd);
    endtask

    task automatic advance();
        bit s;
        bit found;
        @(posedge clk);
        s = model_stall();
        if (m_we) outstanding[m_wr]--;
        if (issue_valid && !s && issue_reg_write && issue_dest != 0) begin
            outstanding[issue_dest]++;
            inflight.push_back(issue_dest);
        end
        if (mem_valid && mem_reg_write && mem_dest != 0) begin
            found = 1'b0;
            for (int i = 0; i < inflight.size(); i++) begin
                if (!found && inflight[i] == mem_dest) begin
                    inflight.delete(i);
                    found = 1'b1;
                end
            end
        end
        m_we = mem_valid && mem_reg_write && (mem_dest != 0);
        m_wr = mem_dest;
        m_wd = mem_to_reg ? mem_read_data : alu_result;
        #1;
    endtask

    task automatic tick();
        settle();
        advance();
    endtask

    initial begin
        model_reset();
        idle();
        set_issue(1, 0, 5'd0, 5'd1, 5'd2, 1);
        #12;
        check("rst_stall", {31'b0, stall}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_we", {31'b0, write_en}, 32'd0);
        check("rst_wr", {27'b0, write_reg}, 32'd0);
        check("rst_wd", write_data, 32'd0);
        rst_n = 1'b1;

        // Clean issue with nothing outstanding
        settle();
        check("t1_stall", {31'b0, stall}, 32'd0);
        advance();

        // RAW hazard on r5
        set_issue(1, 1, 5'd5, 5'd1, 5'd2, 1);
        tick();
        set_issue(1, 0, 5'd0, 5'd5, 5'd0, 0);
        settle();
        check("raw_stall", {31'b0, stall}, 32'd1);
        advance();
        tick();
        set_mem(1, 1, 0, 5'd5, 32'h55, 32'h0);
        settle();
        check("raw_hold", {31'b0, stall}, 32'd1);
        advance();
        set_mem(0, 0, 0, 5'd0, 32'h0, 32'h0);
        settle();
        check("raw_we", {31'b0, write_en}, 32'd1);
        check("raw_wr", {27'b0, write_reg}, 32'd5);
        check("raw_release", {31'b0, stall}, 32'd0);
        advance();
        idle();
        settle();
        check("raw_busy", {31'b0, busy}, 32'd0);
        advance();

        // MemToReg select
        set_issue(1, 1, 5'd8, 5'd0, 5'd0, 0);
        tick();
        idle();
        set_mem(1, 1, 1, 5'd8, 32'h1234, 32'hDEADBEEF);
        tick();
        set_mem(1, 0, 0, 5'd8, 32'h1234, 32'hDEADBEEF);
        settle();
        check("m2r_we", {31'b0, write_en}, 32'd1);
        check("m2r_wr", {27'b0, write_reg}, 32'd8);
        check("m2r_load", write_data, 32'hDEADBEEF);
        advance();
        idle();
        settle();
        check("m2r_alu", write_data, 32'h1234);
        check("m2r_nowrite", {31'b0, write_en}, 32'd0);
        advance();

        // Register 0 is never tracked nor written
        set_issue(1, 1, 5'd0, 5'd0, 5'd0, 0);
        tick();
        idle();
        settle();
        check("r0_busy", {31'b0, busy}, 32'd0);
        advance();
        set_mem(1, 1, 0, 5'd0, 32'hAA, 32'hBB);
        tick();
        idle();
        settle();
        check("r0_we", {31'b0, write_en}, 32'd0);
        advance();
        set_issue(1, 0, 5'd0, 5'd0, 5'd0, 1);
        settle();
        check("r0_stall", {31'b0, stall}, 32'd0);
        advance();

        // Issue to r3 in the same cycle r3 retires with one outstanding
        set_issue(1, 1, 5'd3, 5'd0, 5'd0, 0);
        tick();
        idle();
        set_mem(1, 1, 0, 5'd3, 32'h3, 32'h0);
        tick();
        idle();
        set_issue(1, 1, 5'd3, 5'd0, 5'd0, 0);
        settle();
        check("incdec_we", {31'b0, write_en}, 32'd1);
        check("incdec_wr", {27'b0, write_reg}, 32'd3);
        check("incdec_accept", {31'b0, stall}, 32'd0);
        advance();
        set_issue(1, 0, 5'd0, 5'd3, 5'd0, 0);
        settle();
        check("incdec_pending", {31'b0, stall}, 32'd1);
        check("incdec_busy", {31'b0, busy}, 32'd1);
        advance();
        idle();
        set_mem(1, 1, 0, 5'd3, 32'h3, 32'h0);
        tick();
        idle();
        tick();
        settle();
        check("incdec_clear", {31'b0, busy}, 32'd0);
        advance();

        // Saturation of r3
        repeat (3) begin
            set_issue(1, 1, 5'd3, 5'd0, 5'd0, 0);
            tick();
        end
        set_issue(1, 1, 5'd3, 5'd0, 5'd0, 0);
        settle();
        check("sat_stall", {31'b0, stall}, 32'd1);
        advance();
        idle();
        repeat (3) begin
            set_mem(1, 1, 0, 5'd3, 32'h3, 32'h0);
            tick();
        end
        idle();
        tick();
        settle();
        check("sat_drain", {31'b0, busy}, 32'd0);
        advance();

        // Async reset with r4=2, r7=1 and a write on the port
        set_issue(1, 1, 5'd4, 5'd0, 5'd0, 0);
        tick();
        tick();
        set_issue(1, 1, 5'd7, 5'd0, 5'd0, 0);
        tick();
        set_issue(1, 1, 5'd9, 5'd0, 5'd0, 0);
        tick();
        idle();
        set_mem(1, 1, 0, 5'd9, 32'h99, 32'h0);
        tick();
        idle();
        set_issue(1, 0, 5'd0, 5'd4, 5'd7, 1);
        check("pre_rst_we", {31'b0, write_en}, 32'd1);
        check("pre_rst_busy", {31'b0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("arst_we", {31'b0, write_en}, 32'd0);
        check("arst_wr", {27'b0, write_reg}, 32'd0);
        check("arst_wd", write_data, 32'd0);
        check("arst_busy", {31'b0, busy}, 32'd0);
        check("arst_stall", {31'b0, stall}, 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        advance();
        settle();
        check("post_rst_stall", {31'b0, stall}, 32'd0);
        advance();

        // Random traffic
        repeat (400) begin
            set_issue(($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
                      5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                      5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
            if (inflight.size() > 0 && $urandom_range(0, 1) == 1) begin
                set_mem(1, 1, 1'($urandom_range(0, 1)), inflight[0], $urandom, $urandom);
            end else begin
                set_mem(1'($urandom_range(0, 1)), 0, 1'($urandom_range(0, 1)),
                        5'($urandom_range(0, 7)), $urandom, $urandom);
            end
            tick();
        end

        // Drain everything still outstanding
        set_issue(0, 0, 5'd0, 5'd0, 5'd0, 0);
        for (int n = 0; n < 40; n++) begin
            if (inflight.size() > 0) begin
                set_mem(1, 1, 0, inflight[0], $urandom, $urandom);
            end else begin
                set_mem(0, 0, 0, 5'd0, 32'h0, 32'h0);
            end
            tick();
        end
        idle();
        settle();
        check("drain_busy", {31'b0, busy}, 32'd0);
        advance();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/writeback_scoreboard.md
Name: writeback_scoreboard

Overview:
- Write-back end of the register-file interface: captures MEM-stage results, applies the MemToReg select, and drives the single register-file write port one cycle later.
- Keeps a per-register pending-write scoreboard, fed by the decode stage's issue stream.
- Returns a stall to decode whenever a source register still has an outstanding write.
- Complements the read-only register access performed in decode.

Parameters:
- NUM_REGS, 32, number of architectural registers; register 0 is hard-wired zero.
- CNT_W, 2, width of each pending counter; max in-flight writes per register is 2^CNT_W-1.
- DATA_W, 32, datapath width.

Ports:
- Clk  in  1  rising-edge clock.
- Rst_n  in  1  asynchronous active-low reset.
- IssueValid  in  1  decode presents an instruction this cycle.
- IssueRegWrite  in  1  issued instruction writes a register.
- IssueDest  in  5  destination register (Rd or Rt, already selected by RegDst).
- IssueRs  in  5  source register 1.
- IssueRt  in  5  source register 2.
- IssueUseRt  in  1  instruction reads Rt (R-type, beq/bne, sw).
- Stall  out  1  decode must hold; issue not accepted this cycle.
- MemValid  in  1  MEM stage delivers a retiring instruction.
- MemRegWrite  in  1  retiring instruction writes a register.
- MemToReg  in  1  1 = load data, 0 = ALU result.
- MemDest  in  5  destination register of the retiring instruction.
- ALUResult  in  DATA_W  ALU result.
- MemReadData  in  DATA_W  load data.
- WriteEn  out  1  register-file write enable.
- WriteReg  out  5  register-file write address.
- WriteData  out  DATA_W  register-file write data.
- Busy  out  1  at least one counter is non-zero.

Behaviour:
- Reset (async, Rst_n=0):
  - All counters clear to 0.
  - WriteEn=0, WriteReg=0, WriteData=0.
  - Stall=0 and Busy=0 while in reset.
- WB register:
  - On each Clk edge: WriteEn <= MemValid & MemRegWrite & (MemDest!=0); WriteReg <= MemDest.
  - WriteData <= MemToReg ? MemReadData : ALUResult.
  - Fixed latency: 1 cycle, MEM input to write port.
- Retire event: WriteEn=1 in the current cycle decrements counter[WriteReg] at the next edge.
- Register-file contract:
  - The register file writes in the first half-cycle, so decode reads see WriteData in the same cycle.
  - A counter value of 1 that is retiring this cycle therefore does not count as pending.
- Pending(r) = counter[r] > (retire_r ? 1 : 0), where retire_r = WriteEn & (WriteReg==r). Pending(0) is always 0.
- Stall (combinational), asserted when IssueValid and any of:
  - Pending(IssueRs).
  - IssueUseRt & Pending(IssueRt).
  - IssueRegWrite & IssueDest!=0 & counter[IssueDest]==max & !retire_IssueDest (overflow guard).
- Issue accepted = IssueValid & !Stall. If also IssueRegWrite & IssueDest!=0, counter[IssueDest] increments at the next edge.
- Same-register increment and decrement in one cycle: counter unchanged.
- Register 0: never incremented; a write to register 0 never asserts WriteEn.
- Retire with counter already 0 (protocol error): counter stays 0, no wrap. Assertion fires in simulation.
- Counters never wrap in either direction.
- Busy = OR of all counters, registered view (excludes same-cycle events).
- Reset mid-operation: all pending state is lost immediately.
  - A WB write in the cycle Rst_n falls is suppressed (WriteEn forced 0).
  - Decode sees Stall=0 while reset is asserted.
- No stall on WAW: multiple in-flight writes to one register are counted, up to the counter max.

Test Plan:
1. Reset release, idle inputs -> WriteEn=0, Stall=0, Busy=0. Issue rs=1, rt=2 with no pending writes -> Stall=0.
2. RAW stall:
   - Issue add to r5 at cycle 0, then issue rs=5 at cycle 1 -> Stall=1.
   - Stall holds until the cycle MemValid retire for r5 reaches the WB register: WriteEn=1, WriteReg=5.
   - Stall=0 in that same cycle; counter[5] returns to 0.
3. MemToReg mux:
   - MemToReg=1, MemReadData=0xDEADBEEF, ALUResult=0x1234, MemDest=8 -> next cycle WriteData=0xDEADBEEF, WriteReg=8.
   - MemToReg=0 -> next cycle WriteData=0x1234.
4. Register 0:
   - Issue dest=0 -> counter unchanged, Busy stays 0.
   - Retire MemDest=0 -> WriteEn=0.
   - Issue rs=0 -> Stall=0.
5. Simultaneous inc/dec and saturation:
   - Issue dest=3 in the same cycle r3 retires with counter=1 -> counter stays 1.
   - Three un-retired issues to r3 (CNT_W=2) -> the fourth issue stalls with Stall=1.
6. Async reset mid-flight: counters r4=2 and r7=1, Rst_n pulsed low between edges -> counters=0, Busy=0, and WriteEn drops to 0 immediately, without waiting for a clock edge.
